// File: rtl/mem_line_requester.sv
// -----------------------------------------------------------------------------
// mem_line_requester
//
// Upstream neighbour of the memory controller. Takes whole-cache-line read and
// write requests from the miss-handling logic. It then drives the controller's
// op/address interface and moves the line over the common word-wide data bus:
// a write line is serialised into BEATS word beats, and read beats are
// deserialised back into a line. It returns one response per request.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   req_valid/ready    line request handshake (ready only while idle)
//   req_we             1 = write line, 0 = read line
//   req_addr           byte address of the line (offset bits are dropped)
//   req_wline          write line, word i = bits [32i+31:32i]
//   resp_valid/ready   response handshake
//   resp_we            echo of req_we for this response
//   resp_rline         read line (0 for writes), same word ordering
//   resp_err           protocol error seen during the transfer
//   mc_ready           controller has finished initialisation
//   mc_tx_done         controller transfer-complete pulse
//   mc_rd_valid/rdata  read beat from the controller
//   mc_op              00 idle, 01 read, 11 write (registered)
//   mc_addr            line-aligned address to the controller
//   mc_wdata           write beat to the controller
// -----------------------------------------------------------------------------
module mem_line_requester #(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_BITCOUNT-1:0] req_addr,
    input  logic [CL_SIZE_WIDTH-1:0] req_wline,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_we,
    output logic [CL_SIZE_WIDTH-1:0] resp_rline,
    output logic                     resp_err,
    input  logic                     mc_ready,
    input  logic                     mc_tx_done,
    input  logic                     mc_rd_valid,
    input  logic [WORD_SIZE-1:0]     mc_rdata,
    output logic [1:0]               mc_op,
    output logic [ADDR_BITCOUNT-1:0] mc_addr,
    output logic [WORD_SIZE-1:0]     mc_wdata
);

    localparam int BEATS    = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int CNT_W    = $clog2(BEATS);
    localparam int LINE_OFS = $clog2(CL_SIZE_WIDTH / 8);

    // One extra counter bit so a read beat arriving after the last word is
    // distinguishable from a wrap back to word 0.
    typedef logic [CNT_W:0] cnt_t;
    localparam cnt_t LAST_BEAT = cnt_t'(BEATS - 1);
    localparam cnt_t FULL      = cnt_t'(BEATS);

    localparam logic [ADDR_BITCOUNT-1:0] OFS_MASK =
        {{(ADDR_BITCOUNT - LINE_OFS){1'b0}}, {LINE_OFS{1'b1}}};

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_WR_ARM,
        S_WR_STREAM,
        S_WR_WAIT,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t                     r_state;
    cnt_t                       r_cnt;
    logic [1:0]                 r_mc_op;
    logic [ADDR_BITCOUNT-1:0]   r_mc_addr;
    logic [CL_SIZE_WIDTH-1:0]   r_wbuf;
    logic [WORD_SIZE-1:0]       r_rwords [BEATS];
    logic                       r_we;
    logic                       r_err;

    logic [WORD_SIZE-1:0]       w_wwords [BEATS];
    logic [WORD_SIZE-1:0]       w_wdata;

    for (genvar g = 0; g < BEATS; g++) begin : g_words
        assign w_wwords[g]                              = r_wbuf[g*WORD_SIZE +: WORD_SIZE];
        assign resp_rline[g*WORD_SIZE +: WORD_SIZE]     = r_rwords[g];
    end

    // Write beat mux: the bus carries data only while streaming.
    always_comb begin
        w_wdata = '0;
        if (r_state == S_WR_STREAM) begin
            w_wdata = w_wwords[r_cnt[CNT_W-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_WAIT_INIT;
            r_cnt     <= '0;
            r_mc_op   <= OP_IDLE;
            r_mc_addr <= '0;
            r_wbuf    <= '0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            // NOTE: the read word store is reset because it drives resp_rline
            // directly, and that output has a defined reset value.
            for (int i = 0; i < BEATS; i++) begin
                r_rwords[i] <= '0;
            end
        end else begin
            case (r_state)
                S_WAIT_INIT: begin
                    if (mc_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (req_valid) begin
                        r_mc_addr <= req_addr & ~OFS_MASK;
                        r_wbuf    <= req_wline;
                        r_we      <= req_we;
                        r_cnt     <= '0;
                        r_err     <= 1'b0;
                        // Cleared so a write response returns an all-zero line.
                        for (int i = 0; i < BEATS; i++) begin
                            r_rwords[i] <= '0;
                        end
                        if (req_we) begin
                            r_mc_op <= OP_WRITE;
                            r_state <= S_WR_ARM;
                        end else begin
                            r_mc_op <= OP_READ;
                            r_state <= S_RD_WAIT;
                        end
                    end
                end

                S_WR_ARM: begin
                    r_state <= S_WR_STREAM;
                end

                S_WR_STREAM: begin
                    r_cnt <= r_cnt + cnt_t'(1);
                    if (r_cnt == LAST_BEAT) begin
                        r_state <= S_WR_WAIT;
                    end
                end

                S_WR_WAIT: begin
                    if (mc_tx_done) begin
                        r_mc_op <= OP_IDLE;
                        r_state <= S_RESP;
                    end
                end

                S_RD_WAIT: begin
                    if (mc_rd_valid) begin
                        if (r_cnt == FULL) begin
                            r_err <= 1'b1;        // surplus beat, data dropped
                        end else begin
                            r_rwords[r_cnt[CNT_W-1:0]] <= mc_rdata;
                            r_cnt                      <= r_cnt + cnt_t'(1);
                        end
                    end
                    if (mc_tx_done) begin
                        r_mc_op <= OP_IDLE;
                        r_state <= S_RESP;
                        // Completion must coincide with the final beat.
                        if (!(mc_rd_valid && r_cnt == LAST_BEAT)) begin
                            r_err <= 1'b1;
                        end
                    end
                end

                S_RESP: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_WAIT_INIT;
                end
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_we    = r_we;
    assign resp_err   = r_err;
    assign mc_op      = r_mc_op;
    assign mc_addr    = r_mc_addr;
    assign mc_wdata   = w_wdata;

endmodule

// File: tb/tb_mem_line_requester.sv
// -----------------------------------------------------------------------------
// tb_mem_line_requester
//
// Self-checking bench for mem_line_requester. Inputs change and outputs are
// sampled on the falling clock edge. A table of request records is applied in
// a loop. Expected responses go into a scoreboard queue when each request is
// driven, and they are compared when the response handshake completes. Init
// gating and reset mid-stream are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mem_line_requester;

    localparam int W     = 32;
    localparam int CL    = 512;
    localparam int AB    = 64;
    localparam int BEATS = CL / W;

    typedef logic [CL-1:0] line_t;

    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [AB-1:0] exp_addr;
        logic [W-1:0]  base;        // word i of the line = base + i
        int            nbeats;      // read beats returned (tx_done on the last)
        logic          gap;         // insert idle cycles between read beats
        int            hold;        // cycles resp_ready is held low
        int            done_delay;  // write: extra WR_WAIT cycles before tx_done
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic  we;
        logic  err;
        logic  chk_line;
        line_t line;
    } resp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AB-1:0] req_addr;
    line_t         req_wline;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_we;
    line_t         resp_rline;
    logic          resp_err;
    logic          mc_ready;
    logic          mc_tx_done;
    logic          mc_rd_valid;
    logic [W-1:0]  mc_rdata;
    logic [1:0]    mc_op;
    logic [AB-1:0] mc_addr;
    logic [W-1:0]  mc_wdata;

    always #5 clk = ~clk;

    mem_line_requester #(
        .WORD_SIZE    (W),
        .CL_SIZE_WIDTH(CL),
        .ADDR_BITCOUNT(AB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wline  (req_wline),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_we    (resp_we),
        .resp_rline (resp_rline),
        .resp_err   (resp_err),
        .mc_ready   (mc_ready),
        .mc_tx_done (mc_tx_done),
        .mc_rd_valid(mc_rd_valid),
        .mc_rdata   (mc_rdata),
        .mc_op      (mc_op),
        .mc_addr    (mc_addr),
        .mc_wdata   (mc_wdata)
    );

    int errors = 0;
    int checks = 0;

    resp_t        sb_q [$];
    logic [W-1:0] wq   [$];
    vec_t         vecs [6];

    task automatic check(input string name, input logic [AB-1:0] act, input logic [AB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_line(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mc_op"},      64'(mc_op),      64'd0);
        check({tag, "_mc_addr"},    mc_addr,         64'd0);
        check({tag, "_mc_wdata"},   64'(mc_wdata),   64'd0);
        check({tag, "_req_ready"},  64'(req_ready),  64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_we"},    64'(resp_we),    64'd0);
        check({tag, "_resp_err"},   64'(resp_err),   64'd0);
        check_line({tag, "_resp_rline"}, resp_rline, '0);
    endtask

    // Wait for the response, apply backpressure, then complete the handshake
    // and compare against the scoreboard head.
    task automatic collect_resp(input int hold);
        resp_t e;
        int    n;
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        check("resp_valid_seen", 64'(resp_valid), 64'd1);
        if (!resp_valid) return;
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        resp_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_resp_valid", 64'(resp_valid), 64'd1);
            check("hold_req_ready",  64'(req_ready),  64'd0);
            if (e.chk_line) check_line("hold_resp_rline", resp_rline, e.line);
        end
        resp_ready = 1'b1;
        check("resp_we",  64'(resp_we),  64'(e.we));
        check("resp_err", 64'(resp_err), 64'(e.err));
        if (e.chk_line) check_line("resp_rline", resp_rline, e.line);
        tick();
        resp_ready = 1'b0;
        check("post_hs_resp_valid", 64'(resp_valid), 64'd0);
        check("post_hs_req_ready",  64'(req_ready),  64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        line_t wl;
        resp_t e;
        int    n;
        for (int i = 0; i < BEATS; i++) wl[i*W +: W] = v.base + W'(i);

        e.we       = v.we;
        e.err      = v.exp_err;
        e.chk_line = !v.exp_err;
        e.line     = '0;
        if (!v.we) begin
            for (int i = 0; i < v.nbeats && i < BEATS; i++) e.line[i*W +: W] = v.base + W'(i);
        end else begin
            for (int i = 0; i < BEATS; i++) wq.push_back(v.base + W'(i));
        end
        sb_q.push_back(e);

        req_we    = v.we;
        req_addr  = v.addr;
        req_wline = wl;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("req_ready_seen", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        check("mc_addr", mc_addr, v.exp_addr);

        if (v.we) begin
            check("arm_mc_op",    64'(mc_op),    64'd3);
            check("arm_mc_wdata", 64'(mc_wdata), 64'd0);
            for (int i = 0; i < BEATS; i++) begin
                tick();
                check("wr_beat", 64'(mc_wdata), 64'(wq.pop_front()));
            end
            tick();
            check("wr_wait_mc_op", 64'(mc_op), 64'd3);
            for (int d = 0; d < v.done_delay; d++) tick();
            check("wr_wait_mc_op_held", 64'(mc_op), 64'd3);
            mc_tx_done = 1'b1;
            tick();
            mc_tx_done = 1'b0;
        end else begin
            check("rd_mc_op", 64'(mc_op), 64'd1);
            for (int i = 0; i < v.nbeats; i++) begin
                mc_rd_valid = 1'b1;
                mc_rdata    = v.base + W'(i);
                mc_tx_done  = (i == v.nbeats - 1);
                tick();
                mc_rd_valid = 1'b0;
                mc_tx_done  = 1'b0;
                if (v.gap && (i % 3 == 1) && i < v.nbeats - 1) tick();
            end
        end
        check("done_mc_op", 64'(mc_op), 64'd0);
        collect_resp(v.hold);
    endtask

    initial begin
        int n;
        vecs[0] = '{we:1'b1, addr:64'h1234_5678, exp_addr:64'h1234_5640, base:32'h100,
                    nbeats:0, gap:1'b0, hold:0, done_delay:0, exp_err:1'b0};
        vecs[1] = '{we:1'b0, addr:64'hFFFF_FFFF_FFFF_FFFF, exp_addr:64'hFFFF_FFFF_FFFF_FFC0,
                    base:32'hA0, nbeats:16, gap:1'b1, hold:0, done_delay:0, exp_err:1'b0};
        vecs[2] = '{we:1'b0, addr:64'h40, exp_addr:64'h40, base:32'hB0,
                    nbeats:12, gap:1'b0, hold:0, done_delay:0, exp_err:1'b1};
        vecs[3] = '{we:1'b0, addr:64'h8000_0000_0000_003F, exp_addr:64'h8000_0000_0000_0000,
                    base:32'hC0DE_0000, nbeats:16, gap:1'b0, hold:5, done_delay:0, exp_err:1'b0};
        vecs[4] = '{we:1'b1, addr:64'h0, exp_addr:64'h0, base:32'hDEAD_0000,
                    nbeats:0, gap:1'b0, hold:3, done_delay:0, exp_err:1'b0};
        vecs[5] = '{we:1'b1, addr:64'h7F, exp_addr:64'h40, base:32'h5555_0000,
                    nbeats:0, gap:1'b0, hold:0, done_delay:4, exp_err:1'b0};

        rst_n       = 1'b0;
        req_valid   = 1'b1;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wline   = '0;
        resp_ready  = 1'b0;
        mc_ready    = 1'b0;
        mc_tx_done  = 1'b0;
        mc_rd_valid = 1'b0;
        mc_rdata    = '0;

        // Reset values, then init gating with a request already pending.
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("init_req_ready", 64'(req_ready), 64'd0);
            check("init_mc_op",     64'(mc_op),     64'd0);
        end
        mc_ready = 1'b1;
        tick();
        check("init_done_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(vecs[v]);

        // Reset while beat 7 of a write is on the bus.
        for (int i = 0; i < BEATS; i++) req_wline[i*W +: W] = 32'h700 + W'(i);
        req_we    = 1'b1;
        req_addr  = 64'h3000;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check("rstseq_req_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i <= 7; i++) tick();
        check("rstseq_beat7", 64'(mc_wdata), 64'h707);
        mc_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reinit_req_ready", 64'(req_ready), 64'd0);
        end
        mc_ready = 1'b1;
        tick();
        check("reinit_done_req_ready", 64'(req_ready), 64'd1);
        run_vec(vecs[1]);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
